reg_sequencer: RTL and testbench

- Control stage directly upstream of the register datapath.
- Accepts one instruction at a time over a valid/ready handshake.
- Sequences the 4-bit function codes (Hold/Load/Clear/Shift_Right/Shift_Left) and load data for two downstream registers, A and B.
- Multi-bit shifts are issued as repeated single-bit shift cycles; completion is signalled with a done pulse.

---
 rtl/reg_sequencer_if.sv | 28 ++
 rtl/reg_sequencer.sv | 132 +++++++++++++
 tb/tb_reg_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/reg_sequencer_if.sv
// Bundle between the instruction source / register datapath and the sequencer.
// Handshake: an instruction transfers on a rising clock edge where instr_valid and instr_ready are both 1.
interface reg_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             instr_valid;
    logic [7:0]       instr;
    logic             instr_ready;
    logic [WIDTH-1:0] a_val;
    logic [WIDTH-1:0] b_val;
    logic [3:0]       func_a;
    logic [3:0]       func_b;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       state_dbg;

    modport master (
        output instr_valid, instr, a_val, b_val,
        input  instr_ready, func_a, func_b, data_out, busy, done, err, state_dbg
    );

    modport slave (
        input  instr_valid, instr, a_val, b_val,
        output instr_ready, func_a, func_b, data_out, busy, done, err, state_dbg
    );
endinterface

// File: rtl/reg_sequencer.sv
// Instruction sequencer for two downstream registers A and B: decodes one instruction
// at a time into func codes and load data, expanding multi-bit shifts into single steps.
module reg_sequencer #(
    parameter int         WIDTH   = 4,
    parameter logic [3:0] F_HOLD  = 4'b0000,
    parameter logic [3:0] F_LOAD  = 4'b0001,
    parameter logic [3:0] F_CLEAR = 4'b0010,
    parameter logic [3:0] F_SHR   = 4'b0011,
    parameter logic [3:0] F_SHL   = 4'b0100
) (
    input logic clock,
    input logic reset,
    reg_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_IMM, SRC_A, SRC_B} src_t;

    state_t     state_q;
    logic [3:0] opcode_q;
    logic [3:0] operand_q;
    logic [3:0] count_q;
    logic [3:0] func_a_q, func_b_q;
    src_t       src_q;
    logic       ready_q, busy_q, done_q, err_q;

    logic [3:0] op_in, opr_in;
    logic [3:0] func_a_d, func_b_d;
    src_t       src_d;
    logic       shift_d;

    assign op_in  = bus.instr[7:4];
    assign opr_in = bus.instr[3:0];

    // Decode of the instruction currently offered; only used on the accept edge.
    always_comb begin
        func_a_d = F_HOLD;
        func_b_d = F_HOLD;
        src_d    = SRC_NONE;
        shift_d  = 1'b0;
        case (op_in)
            4'd1:  begin func_a_d = F_LOAD; src_d = SRC_IMM; end
            4'd2:  begin func_b_d = F_LOAD; src_d = SRC_IMM; end
            4'd3:  func_a_d = F_CLEAR;
            4'd4:  func_b_d = F_CLEAR;
            4'd5:  begin shift_d = 1'b1; if (opr_in != 4'd0) func_a_d = F_SHR; end
            4'd6:  begin shift_d = 1'b1; if (opr_in != 4'd0) func_a_d = F_SHL; end
            4'd7:  begin shift_d = 1'b1; if (opr_in != 4'd0) func_b_d = F_SHR; end
            4'd8:  begin shift_d = 1'b1; if (opr_in != 4'd0) func_b_d = F_SHL; end
            4'd9:  begin func_b_d = F_LOAD; src_d = SRC_A; end
            4'd10: begin func_a_d = F_LOAD; src_d = SRC_B; end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= 4'd0;
            operand_q <= 4'd0;
            count_q   <= 4'd0;
            func_a_q  <= F_HOLD;
            func_b_q  <= F_HOLD;
            src_q     <= SRC_NONE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.instr_valid && ready_q) begin
                        opcode_q  <= op_in;
                        operand_q <= opr_in;
                        count_q   <= opr_in;
                        func_a_q  <= func_a_d;
                        func_b_q  <= func_b_d;
                        src_q     <= src_d;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= (shift_d && opr_in != 4'd0) ? S_SHIFT : S_EXEC;
                    end
                end
                S_EXEC: begin
                    func_a_q <= F_HOLD;
                    func_b_q <= F_HOLD;
                    src_q    <= SRC_NONE;
                    done_q   <= 1'b1;
                    err_q    <= (opcode_q > 4'd10);
                    state_q  <= S_DONE;
                end
                S_SHIFT: begin
                    // Shift func stays registered until the final step's edge.
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        func_a_q <= F_HOLD;
                        func_b_q <= F_HOLD;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Reset masks every output in the same cycle so an aborted op cannot reach the registers.
    always_comb begin
        bus.func_a      = reset ? F_HOLD : func_a_q;
        bus.func_b      = reset ? F_HOLD : func_b_q;
        bus.instr_ready = ready_q & ~reset;
        bus.busy        = busy_q & ~reset;
        bus.done        = done_q & ~reset;
        bus.err         = err_q & ~reset;
        bus.state_dbg   = state_q;
        bus.data_out    = '0;
        if (!reset) begin
            case (src_q)
                SRC_IMM: bus.data_out = WIDTH'(operand_q);
                SRC_A:   bus.data_out = bus.a_val;
                SRC_B:   bus.data_out = bus.b_val;
                default: bus.data_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer with a behavioural model of registers A and B.
module tb_reg_sequencer;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] a_reg = '0;
    logic [W-1:0] b_reg = '0;
    int n_cmp = 0;
    int n_err = 0;

    reg_sequencer_if #(.WIDTH(W)) sif ();

    reg_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clock = ~clock;

    assign sif.a_val = a_reg;
    assign sif.b_val = b_reg;

    // Downstream register model
    always @(posedge clock) begin
        case (sif.func_a)
            4'b0001: a_reg <= sif.data_out;
            4'b0010: a_reg <= '0;
            4'b0011: a_reg <= a_reg >> 1;
            4'b0100: a_reg <= a_reg << 1;
            default: ;
        endcase
        case (sif.func_b)
            4'b0001: b_reg <= sif.data_out;
            4'b0010: b_reg <= '0;
            4'b0011: b_reg <= b_reg >> 1;
            4'b0100: b_reg <= b_reg << 1;
            default: ;
        endcase
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Offers instr and returns one cycle after the accept edge (first EXEC/SHIFT cycle).
    task automatic send(input logic [7:0] ins);
        int k;
        sif.instr_valid = 1'b1;
        sif.instr = ins;
        k = 0;
        while (!sif.instr_ready && k < 40) begin
            cyc();
            k++;
        end
        n_cmp++;
        if (!sif.instr_ready) begin
            n_err++;
            $display("FAIL send_timeout instr %h ready got %b exp 1", ins, sif.instr_ready);
        end
        cyc();
        sif.instr_valid = 1'b0;
        sif.instr = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.instr_valid = 1'b0;
        sif.instr = 8'h00;
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++; if (sif.func_a !== 4'h0) begin n_err++; $display("FAIL rst_func_a got %h exp 0", sif.func_a); end
            n_cmp++; if (sif.func_b !== 4'h0) begin n_err++; $display("FAIL rst_func_b got %h exp 0", sif.func_b); end
            n_cmp++; if (sif.instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", sif.instr_ready); end
            n_cmp++; if (sif.done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", sif.done); end
            n_cmp++; if (sif.busy !== 1'b0 || sif.data_out !== 4'h0) begin n_err++; $display("FAIL rst_busy_data got %b/%h exp 0/0", sif.busy, sif.data_out); end
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (sif.instr_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b exp 1", sif.instr_ready); end
        n_cmp++; if (sif.state_dbg !== 2'd0) begin n_err++; $display("FAIL rel_state got %0d exp 0", sif.state_dbg); end
    endtask

    task automatic test_lda();
        send(8'h19);
        n_cmp++; if (sif.func_a !== 4'h1) begin n_err++; $display("FAIL lda_func_a got %h exp 1", sif.func_a); end
        n_cmp++; if (sif.data_out !== 4'h9) begin n_err++; $display("FAIL lda_data got %h exp 9", sif.data_out); end
        n_cmp++; if (sif.func_b !== 4'h0) begin n_err++; $display("FAIL lda_func_b got %h exp 0", sif.func_b); end
        n_cmp++; if (sif.busy !== 1'b1 || sif.done !== 1'b0) begin n_err++; $display("FAIL lda_exec busy/done got %b/%b exp 1/0", sif.busy, sif.done); end
        cyc();
        n_cmp++; if (sif.done !== 1'b1 || sif.err !== 1'b0) begin n_err++; $display("FAIL lda_done done/err got %b/%b exp 1/0", sif.done, sif.err); end
        n_cmp++; if (sif.func_a !== 4'h0 || sif.data_out !== 4'h0) begin n_err++; $display("FAIL lda_done_func got %h/%h exp 0/0", sif.func_a, sif.data_out); end
        n_cmp++; if (a_reg !== 4'h9) begin n_err++; $display("FAIL lda_a_reg got %h exp 9", a_reg); end
        cyc();
        n_cmp++; if (sif.done !== 1'b0 || sif.instr_ready !== 1'b1 || sif.busy !== 1'b0) begin n_err++; $display("FAIL lda_idle done/ready/busy got %b/%b/%b exp 0/1/0", sif.done, sif.instr_ready, sif.busy); end
    endtask

    task automatic test_shift();
        send(8'h11);
        cyc();
        send(8'h63);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (sif.func_a !== 4'h4 || sif.done !== 1'b0) begin n_err++; $display("FAIL shla_step%0d func/done got %h/%b exp 4/0", i, sif.func_a, sif.done); end
            cyc();
        end
        n_cmp++; if (sif.done !== 1'b1 || sif.func_a !== 4'h0) begin n_err++; $display("FAIL shla_done done/func got %b/%h exp 1/0", sif.done, sif.func_a); end
        n_cmp++; if (a_reg !== 4'b1000) begin n_err++; $display("FAIL shla_a_reg got %b exp 1000", a_reg); end
        cyc();
        send(8'h50);
        n_cmp++; if (sif.func_a !== 4'h0 || sif.busy !== 1'b1 || sif.done !== 1'b0) begin n_err++; $display("FAIL shr0_exec func/busy/done got %h/%b/%b exp 0/1/0", sif.func_a, sif.busy, sif.done); end
        cyc();
        n_cmp++; if (sif.done !== 1'b1 || sif.err !== 1'b0) begin n_err++; $display("FAIL shr0_done done/err got %b/%b exp 1/0", sif.done, sif.err); end
        n_cmp++; if (a_reg !== 4'b1000) begin n_err++; $display("FAIL shr0_a_reg got %b exp 1000", a_reg); end
        cyc();
    endtask

    task automatic test_move_illegal();
        send(8'h15);
        cyc();
        send(8'h90);
        n_cmp++; if (sif.func_b !== 4'h1 || sif.data_out !== 4'h5 || sif.func_a !== 4'h0) begin n_err++; $display("FAIL movab fb/data/fa got %h/%h/%h exp 1/5/0", sif.func_b, sif.data_out, sif.func_a); end
        cyc();
        n_cmp++; if (b_reg !== 4'h5) begin n_err++; $display("FAIL movab_b_reg got %h exp 5", b_reg); end
        cyc();
        send(8'hF0);
        n_cmp++; if (sif.func_a !== 4'h0 || sif.func_b !== 4'h0 || sif.data_out !== 4'h0) begin n_err++; $display("FAIL illegal_exec fa/fb/data got %h/%h/%h exp 0/0/0", sif.func_a, sif.func_b, sif.data_out); end
        cyc();
        n_cmp++; if (sif.done !== 1'b1 || sif.err !== 1'b1) begin n_err++; $display("FAIL illegal_done done/err got %b/%b exp 1/1", sif.done, sif.err); end
        cyc();
        n_cmp++; if (sif.err !== 1'b0) begin n_err++; $display("FAIL illegal_err_pulse got %b exp 0", sif.err); end
    endtask

    task automatic test_back_to_back();
        // LDB 3, CLRA, MOVBA, SHRB 5 issued with no idle gap
        send(8'h23);
        n_cmp++; if (sif.func_b !== 4'h1 || sif.data_out !== 4'h3) begin n_err++; $display("FAIL ldb fb/data got %h/%h exp 1/3", sif.func_b, sif.data_out); end
        send(8'h30);
        n_cmp++; if (sif.func_a !== 4'h2 || b_reg !== 4'h3) begin n_err++; $display("FAIL clra fa/b_reg got %h/%h exp 2/3", sif.func_a, b_reg); end
        send(8'hA0);
        n_cmp++; if (sif.func_a !== 4'h1 || sif.data_out !== 4'h3 || a_reg !== 4'h0) begin n_err++; $display("FAIL movba fa/data/a_reg got %h/%h/%h exp 1/3/0", sif.func_a, sif.data_out, a_reg); end
        send(8'h75);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (sif.func_b !== 4'h3 || sif.func_a !== 4'h0) begin n_err++; $display("FAIL shrb_step%0d fb/fa got %h/%h exp 3/0", i, sif.func_b, sif.func_a); end
            cyc();
        end
        n_cmp++; if (sif.done !== 1'b1 || b_reg !== 4'h0 || a_reg !== 4'h3) begin n_err++; $display("FAIL shrb_done done/b/a got %b/%h/%h exp 1/0/3", sif.done, b_reg, a_reg); end
        cyc();
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] a_before;
        send(8'h6F);
        sif.instr_valid = 1'b1;
        sif.instr = 8'h19;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (sif.func_a !== 4'h4 || sif.instr_ready !== 1'b0) begin n_err++; $display("FAIL abort_step%0d fa/ready got %h/%b exp 4/0", i, sif.func_a, sif.instr_ready); end
            cyc();
        end
        reset = 1'b1;
        #1;
        a_before = a_reg;
        n_cmp++; if (sif.func_a !== 4'h0 || sif.done !== 1'b0) begin n_err++; $display("FAIL abort_rst fa/done got %h/%b exp 0/0", sif.func_a, sif.done); end
        sif.instr_valid = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        n_cmp++; if (sif.state_dbg !== 2'd0 || sif.instr_ready !== 1'b1 || sif.busy !== 1'b0) begin n_err++; $display("FAIL abort_idle state/ready/busy got %0d/%b/%b exp 0/1/0", sif.state_dbg, sif.instr_ready, sif.busy); end
        n_cmp++; if (a_reg !== a_before) begin n_err++; $display("FAIL abort_a_reg got %h exp %h", a_reg, a_before); end
        cyc();
        n_cmp++; if (sif.done !== 1'b0 || sif.func_a !== 4'h0) begin n_err++; $display("FAIL abort_nodone done/fa got %b/%h exp 0/0", sif.done, sif.func_a); end
    endtask

    initial begin
        sif.instr_valid = 1'b0;
        sif.instr = 8'h00;
        test_reset();
        test_lda();
        test_shift();
        test_move_illegal();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
